// File: rtl/fft_input_loader.sv
// Serial-to-parallel loader that packs 32 complex samples into one frame for the FFT butterflies.
// Define FFT_INPUT_BITREV_EN to store samples in DIT bit-reversed slot order instead of natural order.
module fft_input_loader #(
    parameter int N = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    in_r,
    input  logic [N-1:0]    in_i,
    input  logic            in_valid,
    input  logic            in_sof,
    output logic            in_ready,
    output logic [32*N-1:0] frame_r,
    output logic [32*N-1:0] frame_i,
    output logic            frame_valid,
    input  logic            frame_ready,
    output logic [4:0]      load_cnt,
    output logic            sync_err
);

    typedef enum logic {
        S_FILL = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t     r_state;
    state_t     w_state_next;
    logic       r_in_ready;
    logic       r_frame_valid;
    logic       r_sync_err;
    logic [4:0] r_load_cnt;

    logic       w_in_ready_next;
    logic       w_frame_valid_next;
    logic       w_sync_err_next;
    logic [4:0] w_load_cnt_next;

    logic       w_accept;
    logic [4:0] w_cnt_sel;
    logic [4:0] w_wr_addr;

    // in_ready is registered, so HOLD (in_ready=0) naturally blocks every accept.
    assign w_accept  = in_valid & r_in_ready;
    assign w_cnt_sel = in_sof ? 5'd0 : r_load_cnt;

`ifdef FFT_INPUT_BITREV_EN
    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_bitrev
            assign w_wr_addr[gi] = w_cnt_sel[4-gi];
        end
    endgenerate
`else
    assign w_wr_addr = w_cnt_sel;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_FILL;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_FILL: begin
                if (w_accept && !in_sof && (r_load_cnt == 5'd31)) begin
                    w_state_next = S_HOLD;
                end
            end
            S_HOLD: begin
                if (frame_ready) begin
                    w_state_next = S_FILL;
                end
            end
            default: w_state_next = S_FILL;
        endcase
    end

    // Handshake outputs are computed from the next state and registered below.
    always_comb begin
        w_in_ready_next    = (w_state_next == S_FILL);
        w_frame_valid_next = (w_state_next == S_HOLD);
        w_sync_err_next    = w_accept & in_sof & (r_load_cnt != 5'd0);
        w_load_cnt_next    = r_load_cnt;
        if (w_accept) begin
            w_load_cnt_next = in_sof ? 5'd1 : r_load_cnt + 5'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_in_ready    <= 1'b0;
            r_frame_valid <= 1'b0;
            r_sync_err    <= 1'b0;
            r_load_cnt    <= 5'd0;
        end else begin
            r_in_ready    <= w_in_ready_next;
            r_frame_valid <= w_frame_valid_next;
            r_sync_err    <= w_sync_err_next;
            r_load_cnt    <= w_load_cnt_next;
        end
    end

    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_slot
            logic [N-1:0] r_slot_r;
            logic [N-1:0] r_slot_i;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_slot_r <= '0;
                    r_slot_i <= '0;
                end else if (w_accept && (w_wr_addr == 5'(gi))) begin
                    r_slot_r <= in_r;
                    r_slot_i <= in_i;
                end
            end

            assign frame_r[gi*N +: N] = r_slot_r;
            assign frame_i[gi*N +: N] = r_slot_i;
        end
    endgenerate

    assign in_ready    = r_in_ready;
    assign frame_valid = r_frame_valid;
    assign sync_err    = r_sync_err;
    assign load_cnt    = r_load_cnt;

endmodule

// File: tb/tb_fft_input_loader.sv
// Directed bench for fft_input_loader: table-driven frame load plus backpressure, restart, gap and reset sequences.
module tb_fft_input_loader;

    localparam int N = 16;

    logic            clk;
    logic            rst;
    logic [N-1:0]    in_r;
    logic [N-1:0]    in_i;
    logic            in_valid;
    logic            in_sof;
    logic            in_ready;
    logic [32*N-1:0] frame_r;
    logic [32*N-1:0] frame_i;
    logic            frame_valid;
    logic            frame_ready;
    logic [4:0]      load_cnt;
    logic            sync_err;

    fft_input_loader #(.N(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_r        (in_r),
        .in_i        (in_i),
        .in_valid    (in_valid),
        .in_sof      (in_sof),
        .in_ready    (in_ready),
        .frame_r     (frame_r),
        .frame_i     (frame_i),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .load_cnt    (load_cnt),
        .sync_err    (sync_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         v;
        logic         sof;
        logic [N-1:0] r;
        logic [N-1:0] i;
        logic         fr;
        logic         e_rdy;
        logic         e_fv;
        logic [4:0]   e_cnt;
        logic         e_serr;
    } vec_t;

    vec_t         tbl [32];
    logic [N-1:0] exp_r [32];
    logic [N-1:0] exp_i [32];
    int           n_tests = 0;
    int           n_fail  = 0;

    function automatic logic [4:0] slot_of(input int c);
        logic [4:0] a;
        logic [4:0] b;
        a = 5'(c);
        b = a;
`ifdef FFT_INPUT_BITREV_EN
        for (int j = 0; j < 5; j++) b[j] = a[4-j];
`endif
        return b;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_frame(input string tag);
        for (int s = 0; s < 32; s++) begin
            chk($sformatf("%s slot%0d re", tag, s), 64'(frame_r[s*N +: N]), 64'(exp_r[s]));
            chk($sformatf("%s slot%0d im", tag, s), 64'(frame_i[s*N +: N]), 64'(exp_i[s]));
        end
    endtask

    task automatic send(input logic v, input logic sof, input logic [N-1:0] r,
                        input logic [N-1:0] i, input logic fr);
        in_valid    = v;
        in_sof      = sof;
        in_r        = r;
        in_i        = i;
        frame_ready = fr;
        @(posedge clk);
        #1;
    endtask

    task automatic set_natural_expect();
        for (int k = 0; k < 32; k++) begin
            exp_r[slot_of(k)] = N'(k);
            exp_i[slot_of(k)] = N'(-k);
        end
    endtask

    task automatic release_frame(input string tag);
        send(1'b0, 1'b0, '0, '0, 1'b1);
        chk({tag, " release fv"}, 64'(frame_valid), 64'd0);
        chk({tag, " release rdy"}, 64'(in_ready), 64'd1);
        frame_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 32; k++) begin
            tbl[k].v      = 1'b1;
            tbl[k].sof    = (k == 0);
            tbl[k].r      = N'(k);
            tbl[k].i      = N'(-k);
            tbl[k].fr     = 1'b0;
            tbl[k].e_rdy  = (k != 31);
            tbl[k].e_fv   = (k == 31);
            tbl[k].e_cnt  = 5'((k + 1) % 32);
            tbl[k].e_serr = 1'b0;
        end

        rst = 1'b0; in_valid = 1'b0; in_sof = 1'b0;
        in_r = '0; in_i = '0; frame_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset rdy", 64'(in_ready), 64'd0);
        chk("reset fv", 64'(frame_valid), 64'd0);
        chk("reset cnt", 64'(load_cnt), 64'd0);
        chk("reset serr", 64'(sync_err), 64'd0);
        chk("reset frame", 64'(|{frame_r, frame_i}), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("pre-edge rdy", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        chk("post-release rdy", 64'(in_ready), 64'd1);

        $display("[TB] phase: natural frame from vector table");
        for (int k = 0; k < 32; k++) begin
            send(tbl[k].v, tbl[k].sof, tbl[k].r, tbl[k].i, tbl[k].fr);
            chk($sformatf("vec%0d rdy", k), 64'(in_ready), 64'(tbl[k].e_rdy));
            chk($sformatf("vec%0d fv", k), 64'(frame_valid), 64'(tbl[k].e_fv));
            chk($sformatf("vec%0d cnt", k), 64'(load_cnt), 64'(tbl[k].e_cnt));
            chk($sformatf("vec%0d serr", k), 64'(sync_err), 64'(tbl[k].e_serr));
        end
        set_natural_expect();
        check_frame("frame1");
`ifdef FFT_INPUT_BITREV_EN
        chk("bitrev slot1", 64'(frame_r[1*N +: N]), 64'd16);
        chk("bitrev slot2", 64'(frame_r[2*N +: N]), 64'd8);
        chk("bitrev slot31", 64'(frame_r[31*N +: N]), 64'd31);
`else
        chk("natural slot1", 64'(frame_r[1*N +: N]), 64'd1);
        chk("natural slot31", 64'(frame_r[31*N +: N]), 64'd31);
`endif

        $display("[TB] phase: backpressure in HOLD");
        for (int c = 0; c < 10; c++) begin
            send(1'b1, c[0], 16'h7777, 16'h1111, 1'b0);
            chk($sformatf("hold%0d fv", c), 64'(frame_valid), 64'd1);
            chk($sformatf("hold%0d rdy", c), 64'(in_ready), 64'd0);
            chk($sformatf("hold%0d cnt", c), 64'(load_cnt), 64'd0);
            chk($sformatf("hold%0d serr", c), 64'(sync_err), 64'd0);
        end
        check_frame("held");
        release_frame("bp");
        check_frame("after release");

        $display("[TB] phase: early restart at load_cnt=7");
        for (int k = 0; k < 7; k++) begin
            send(1'b1, (k == 0), N'(100 + k), N'(-(100 + k)), 1'b0);
            chk($sformatf("pre%0d serr", k), 64'(sync_err), 64'd0);
        end
        chk("pre cnt", 64'(load_cnt), 64'd7);
        send(1'b1, 1'b1, N'(200), N'(-200), 1'b0);
        chk("restart serr", 64'(sync_err), 64'd1);
        chk("restart cnt", 64'(load_cnt), 64'd1);
        for (int j = 1; j < 32; j++) begin
            send(1'b1, 1'b0, N'(200 + j), N'(-(200 + j)), 1'b0);
            if (j == 1) chk("restart serr drop", 64'(sync_err), 64'd0);
            chk($sformatf("restart%0d fv", j), 64'(frame_valid), 64'(j == 31));
        end
        for (int j = 0; j < 32; j++) begin
            exp_r[slot_of(j)] = N'(200 + j);
            exp_i[slot_of(j)] = N'(-(200 + j));
        end
        check_frame("restart");
        release_frame("rs");

        $display("[TB] phase: gapped input");
        for (int k = 0; k < 32; k++) begin
            send(1'b1, (k == 0), N'(k), N'(-k), 1'b0);
            chk($sformatf("gap%0d cnt", k), 64'(load_cnt), 64'((k + 1) % 32));
            chk($sformatf("gap%0d fv", k), 64'(frame_valid), 64'(k == 31));
            if (k < 31) begin
                send(1'b0, 1'b1, 16'hdead, 16'hbeef, 1'b0);
                chk($sformatf("gap%0d idle cnt", k), 64'(load_cnt), 64'(k + 1));
                chk($sformatf("gap%0d idle serr", k), 64'(sync_err), 64'd0);
            end
        end
        set_natural_expect();
        check_frame("gapped");
        release_frame("gp");

        $display("[TB] phase: sof on 32nd accept");
        for (int k = 0; k < 31; k++) send(1'b1, (k == 0), N'(k), N'(-k), 1'b0);
        chk("sof32 pre cnt", 64'(load_cnt), 64'd31);
        send(1'b1, 1'b1, N'(500), N'(-500), 1'b0);
        chk("sof32 serr", 64'(sync_err), 64'd1);
        chk("sof32 cnt", 64'(load_cnt), 64'd1);
        chk("sof32 fv", 64'(frame_valid), 64'd0);
        chk("sof32 rdy", 64'(in_ready), 64'd1);

        $display("[TB] phase: reset mid-frame");
        for (int k = 1; k < 20; k++) send(1'b1, 1'b0, N'(50 + k), N'(60 + k), 1'b0);
        chk("midrst pre cnt", 64'(load_cnt), 64'd20);
        rst = 1'b0;
        #1;
        chk("midrst cnt", 64'(load_cnt), 64'd0);
        chk("midrst rdy", 64'(in_ready), 64'd0);
        chk("midrst fv", 64'(frame_valid), 64'd0);
        chk("midrst frame", 64'(|{frame_r, frame_i}), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst release rdy", 64'(in_ready), 64'd1);
        for (int k = 0; k < 32; k++) begin
            send(1'b1, (k == 0), N'(k), N'(-k), 1'b0);
            chk($sformatf("post%0d fv", k), 64'(frame_valid), 64'(k == 31));
        end
        set_natural_expect();
        check_frame("post reset");
        chk("post reset serr", 64'(sync_err), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
